u_type_encoder: RTL and testbench

- Instruction encoder. It is the write-side counterpart of the U-type control decoder.
- Accepts an encode request: op, destination register and 32-bit immediate. Emits RV32I instruction words: LUI, AUIPC, or the LI pseudo-instruction expanded into LUI+ADDI.
- Sits in the test/boot path and feeds instruction memory or the core's instruction-fetch stub.
- Uses valid/ready handshakes on both sides, with a one-entry registered output.

---
 rtl/u_type_encoder_pkg.sv | 80 ++++++++
 rtl/u_type_li_split.sv | 31 +++
 rtl/u_type_encoder.sv | 159 +++++++++++++++
 tb/tb_u_type_encoder.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/u_type_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : u_type_encoder_pkg
// Purpose  : Shared constants for the U-type encoder and its matching
//            decoders: RV32I opcodes, request-op encodings, FSM state type,
//            control-bundle field positions, per-instruction bundle values
//            and instruction-word packing helpers.
// Revision : 1.0 - initial release
// ============================================================================
package u_type_encoder_pkg;

   // RV32I major opcodes
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;

   // Request-op encodings
   localparam logic [1:0] REQ_OP_LUI   = 2'b00;
   localparam logic [1:0] REQ_OP_AUIPC = 2'b01;
   localparam logic [1:0] REQ_OP_LI    = 2'b10;
   localparam logic [1:0] REQ_OP_ILL   = 2'b11;

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_EMIT_LO = 1'b1
   } enc_state_t;

   // Control-bundle layout, MSB first:
   // {we_reg, we_mem, npc_sel, immgen_op[2:0], alu_op[3:0], bralu_op[2:0],
   //  alu_asel[1:0], alu_bsel[1:0], wb_sel[1:0], memdata_width[2:0]}
   localparam int SIGN_W           = 22;
   localparam int SIGN_WE_REG      = 21;
   localparam int SIGN_WE_MEM      = 20;
   localparam int SIGN_NPC_SEL     = 19;
   localparam int SIGN_IMMGEN_LSB  = 16;
   localparam int SIGN_ALU_OP_LSB  = 12;
   localparam int SIGN_BRALU_LSB   = 9;
   localparam int SIGN_ASEL_LSB    = 7;
   localparam int SIGN_BSEL_LSB    = 5;
   localparam int SIGN_WB_SEL_LSB  = 3;
   localparam int SIGN_MEMW_LSB    = 0;

   localparam logic [SIGN_W-1:0] SIGN_LUI =
        (22'd1 << SIGN_WE_REG)
      | (22'd4 << SIGN_IMMGEN_LSB)
      | (22'd0 << SIGN_ASEL_LSB)
      | (22'd2 << SIGN_BSEL_LSB)
      | (22'd1 << SIGN_WB_SEL_LSB);

   localparam logic [SIGN_W-1:0] SIGN_AUIPC =
        (22'd1 << SIGN_WE_REG)
      | (22'd4 << SIGN_IMMGEN_LSB)
      | (22'd2 << SIGN_ASEL_LSB)
      | (22'd2 << SIGN_BSEL_LSB)
      | (22'd1 << SIGN_WB_SEL_LSB);

   localparam logic [SIGN_W-1:0] SIGN_ADDI =
        (22'd1 << SIGN_WE_REG)
      | (22'd1 << SIGN_IMMGEN_LSB)
      | (22'd1 << SIGN_ASEL_LSB)
      | (22'd2 << SIGN_BSEL_LSB)
      | (22'd1 << SIGN_WB_SEL_LSB);

   // {imm[31:12], rd, opcode}
   function automatic logic [31:0] enc_u_type(input logic [19:0] imm20,
                                              input logic [4:0]  rd,
                                              input logic [6:0]  opc);
      return {imm20, rd, opc};
   endfunction

   // ADDI rd, rs1, imm12
   function automatic logic [31:0] enc_addi(input logic [11:0] imm12,
                                            input logic [4:0]  rs1,
                                            input logic [4:0]  rd);
      return {imm12, rs1, 3'b000, rd, OPC_OPIMM};
   endfunction

endpackage : u_type_encoder_pkg

`default_nettype wire

// File: rtl/u_type_li_split.sv
`default_nettype none
// ============================================================================
// Module   : u_type_li_split
// Purpose  : Combinational split of a 32-bit LI immediate into the LUI upper
//            part and the ADDI lower part, plus single-word shortcuts.
// Ports    : imm         in  32  immediate to load
//            hi          out 20  LUI immediate, (imm + 0x800) >> 12, wrapping
//            lo          out 12  ADDI immediate, imm[11:0]
//            single_addi out 1   hi == 0, one ADDI rd,x0,lo suffices
//            single_lui  out 1   hi != 0 and lo == 0, one LUI suffices
// Revision : 1.0 - initial release
// ============================================================================
module u_type_li_split (
   input  logic [31:0] imm,
   output logic [19:0] hi,
   output logic [11:0] lo,
   output logic        single_addi,
   output logic        single_lui
);

   // Adding 0x800 before the shift only carries into bit 12 when imm[11]
   // is set, so the upper part is imm[31:12] plus that bit, wrapping at
   // 20 bits exactly like the 32-bit modular add would.
   assign hi          = imm[31:12] + {19'd0, imm[11]};
   assign lo          = imm[11:0];
   assign single_addi = (hi == 20'd0);
   assign single_lui  = (hi != 20'd0) && (lo == 12'd0);

endmodule : u_type_li_split

`default_nettype wire

// File: rtl/u_type_encoder.sv
`default_nettype none
// ============================================================================
// Module   : u_type_encoder
// Purpose  : Encodes LUI / AUIPC / LI requests into RV32I instruction words
//            with valid/ready on both sides and a one-entry output register.
//            LI expands to ADDI, LUI, or LUI followed by ADDI.
// Ports    : clk, rstn (async, active-low)
//            req_valid/req_ready, req_op[1:0], req_rd[RD_W-1:0], req_imm[31:0]
//            out_valid/out_ready, out_inst[31:0], out_last
//            out_sign[21:0]  decoder control bundle (U_TYPE_ENC_SIGN_EN only)
//            err             one-cycle pulse after an illegal op is accepted
// Config   : define U_TYPE_ENC_SIGN_EN to add the out_sign port.
// Revision : 1.0 - initial release
// ============================================================================
module u_type_encoder
   import u_type_encoder_pkg::*;
#(
   parameter int RD_W = 5,
   parameter int XLEN = 32      // only 32 is supported
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [1:0]      req_op,
   input  logic [RD_W-1:0] req_rd,
   input  logic [XLEN-1:0] req_imm,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_inst,
   output logic            out_last,
`ifdef U_TYPE_ENC_SIGN_EN
   output logic [21:0]     out_sign,
`endif
   output logic            err
);

   enc_state_t      r_state;
   logic            r_out_valid;
   logic [XLEN-1:0] r_out_inst;
   logic            r_out_last;
   logic            r_err;
   logic [XLEN-1:0] r_lo_inst;     // ADDI word waiting behind a LUI
`ifdef U_TYPE_ENC_SIGN_EN
   logic [21:0]     r_out_sign;
`endif

   logic            w_accept;
   logic            w_drain;
   logic [19:0]     w_hi;
   logic [11:0]     w_lo;
   logic            w_single_addi;
   logic            w_single_lui;
   logic [31:0]     w_u_word;
   logic [31:0]     w_li_lui;
   logic [31:0]     w_li_addi_x0;
   logic [31:0]     w_li_addi_rd;

   u_type_li_split u_split (
      .imm         (req_imm),
      .hi          (w_hi),
      .lo          (w_lo),
      .single_addi (w_single_addi),
      .single_lui  (w_single_lui)
   );

   // No new request while a LUI of a two-word LI is still queued or the
   // output register is full and not draining this edge.
   assign req_ready = rstn && (r_state == ST_IDLE) && (!r_out_valid || out_ready);
   assign w_accept  = req_valid && req_ready;
   assign w_drain   = r_out_valid && out_ready;

   assign w_u_word     = enc_u_type(req_imm[31:12], req_rd,
                                    (req_op == REQ_OP_AUIPC) ? OPC_AUIPC : OPC_LUI);
   assign w_li_lui     = enc_u_type(w_hi, req_rd, OPC_LUI);
   assign w_li_addi_x0 = enc_addi(w_lo, 5'd0, req_rd);
   assign w_li_addi_rd = enc_addi(w_lo, req_rd, req_rd);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= ST_IDLE;
         r_out_valid <= 1'b0;
         r_out_inst  <= '0;
         r_out_last  <= 1'b0;
         r_err       <= 1'b0;
         r_lo_inst   <= '0;
`ifdef U_TYPE_ENC_SIGN_EN
         r_out_sign  <= '0;
`endif
      end else begin
         r_err <= w_accept && (req_op == REQ_OP_ILL);
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  case (req_op)
                     REQ_OP_LUI, REQ_OP_AUIPC: begin
                        r_out_valid <= 1'b1;
                        r_out_inst  <= w_u_word;
                        r_out_last  <= 1'b1;
`ifdef U_TYPE_ENC_SIGN_EN
                        r_out_sign  <= (req_op == REQ_OP_AUIPC) ? SIGN_AUIPC : SIGN_LUI;
`endif
                     end
                     REQ_OP_LI: begin
                        r_out_valid <= 1'b1;
                        if (w_single_addi) begin
                           r_out_inst <= w_li_addi_x0;
                           r_out_last <= 1'b1;
`ifdef U_TYPE_ENC_SIGN_EN
                           r_out_sign <= SIGN_ADDI;
`endif
                        end else begin
                           r_out_inst <= w_li_lui;
                           r_out_last <= w_single_lui;
`ifdef U_TYPE_ENC_SIGN_EN
                           r_out_sign <= SIGN_LUI;
`endif
                           if (!w_single_lui) begin
                              r_lo_inst <= w_li_addi_rd;
                              r_state   <= ST_EMIT_LO;
                           end
                        end
                     end
                     default: begin
                        // Illegal op: consumed without producing a word.
                        r_out_valid <= 1'b0;
                     end
                  endcase
               end else if (w_drain) begin
                  r_out_valid <= 1'b0;
               end
            end
            ST_EMIT_LO: begin
               // LUI handshakes: swap in the ADDI word on the same edge.
               if (w_drain) begin
                  r_out_inst <= r_lo_inst;
                  r_out_last <= 1'b1;
`ifdef U_TYPE_ENC_SIGN_EN
                  r_out_sign <= SIGN_ADDI;
`endif
                  r_state    <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign out_valid = r_out_valid;
   assign out_inst  = r_out_inst;
   assign out_last  = r_out_last;
   assign err       = r_err;
`ifdef U_TYPE_ENC_SIGN_EN
   assign out_sign  = r_out_sign;
`endif

endmodule : u_type_encoder

`default_nettype wire

// File: tb/tb_u_type_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_u_type_encoder
// Purpose  : Self-checking bench for u_type_encoder: directed scenarios plus
//            randomized requests scored against an arithmetic reference model.
// Config   : define U_TYPE_ENC_SIGN_EN to also check out_sign.
// Revision : 1.0 - initial release
// ============================================================================
module tb_u_type_encoder;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_op = 2'b00;
   logic [4:0]  req_rd = 5'd0;
   logic [31:0] req_imm = 32'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_inst;
   logic        out_last;
   logic        err;
`ifdef U_TYPE_ENC_SIGN_EN
   logic [21:0] out_sign;
   localparam logic [21:0] C_SIGN_LUI   = {1'b1,1'b0,1'b0,3'b100,4'b0,3'b0,2'b00,2'b10,2'b01,3'b0};
   localparam logic [21:0] C_SIGN_AUIPC = {1'b1,1'b0,1'b0,3'b100,4'b0,3'b0,2'b10,2'b10,2'b01,3'b0};
   localparam logic [21:0] C_SIGN_ADDI  = {1'b1,1'b0,1'b0,3'b001,4'b0,3'b0,2'b01,2'b10,2'b01,3'b0};
`endif

   int n_checks = 0;
   int n_fail   = 0;
   bit rand_bp  = 1'b0;
   logic [32:0] exp_q[$];
   logic [32:0] obs_q[$];
   int exp_err = 0;
   int obs_err = 0;

   u_type_encoder #(.RD_W(5), .XLEN(32)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_rd    (req_rd),
      .req_imm   (req_imm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_inst  (out_inst),
      .out_last  (out_last),
`ifdef U_TYPE_ENC_SIGN_EN
      .out_sign  (out_sign),
`endif
      .err       (err)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [31:0] m_upper(input logic [31:0] upper, input logic [4:0] rd,
                                           input logic [31:0] opc);
      return (upper << 12) | ({27'd0, rd} << 7) | opc;
   endfunction

   function automatic logic [31:0] m_addi(input logic [31:0] lo, input logic [4:0] rs1,
                                          input logic [4:0] rd);
      return (lo << 20) | ({27'd0, rs1} << 15) | ({27'd0, rd} << 7) | 32'h13;
   endfunction

   task automatic model_push(input logic [1:0] op, input logic [4:0] rd, input logic [31:0] imm);
      logic [31:0] hi;
      logic [31:0] lo;
      hi = (imm + 32'h800) >> 12;
      lo = imm & 32'hFFF;
      case (op)
         2'd0: exp_q.push_back({1'b1, m_upper(imm >> 12, rd, 32'h37)});
         2'd1: exp_q.push_back({1'b1, m_upper(imm >> 12, rd, 32'h17)});
         2'd2: begin
            if (hi == 0)
               exp_q.push_back({1'b1, m_addi(lo, 5'd0, rd)});
            else if (lo == 0)
               exp_q.push_back({1'b1, m_upper(hi, rd, 32'h37)});
            else begin
               exp_q.push_back({1'b0, m_upper(hi, rd, 32'h37)});
               exp_q.push_back({1'b1, m_addi(lo, rd, rd)});
            end
         end
         default: exp_err++;
      endcase
   endtask

   // Handshake monitor, sampled mid-cycle so values are those the next edge sees.
   always @(negedge clk) begin
      if (rstn) begin
         if (req_valid && req_ready) model_push(req_op, req_rd, req_imm);
         if (out_valid && out_ready) obs_q.push_back({out_last, out_inst});
         if (err) obs_err++;
      end
   end

   // Presents a request (called just after a rising edge) and returns just
   // after the edge that accepted it.
   task automatic drive_req(input logic [1:0] op, input logic [4:0] rd, input logic [31:0] imm);
      bit done;
      done = 1'b0;
      req_op = op; req_rd = rd; req_imm = imm; req_valid = 1'b1;
      for (int i = 0; i < 64 && !done; i++) begin
         if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (req_ready) done = 1'b1;
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      if (!done) begin
         n_checks++; n_fail++;
         $display("FAIL drive_req_timeout: req_ready=%b required 1 within 64 cycles", req_ready);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset;
      out_ready = 1'b1;
      rstn = 1'b0;
      #12;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      n_checks++; if (out_inst !== 32'd0) begin n_fail++; $display("FAIL reset_inst: got %h want 0", out_inst); end
      n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", out_last); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
      n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", req_ready); end
`ifdef U_TYPE_ENC_SIGN_EN
      n_checks++; if (out_sign !== 22'd0) begin n_fail++; $display("FAIL reset_sign: got %h want 0", out_sign); end
`endif
      @(posedge clk); #1;
      rstn = 1'b1;
      #1;
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b want 1", req_ready); end
      @(posedge clk); #1;
   endtask

   task automatic test_lui;
      drive_req(2'd0, 5'd5, 32'h12345000);
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL lui_valid: got %b want 1", out_valid); end
      n_checks++; if (out_inst !== 32'h123452B7) begin n_fail++; $display("FAIL lui_inst: got %h want 123452b7", out_inst); end
      n_checks++; if (out_last !== 1'b1) begin n_fail++; $display("FAIL lui_last: got %b want 1", out_last); end
`ifdef U_TYPE_ENC_SIGN_EN
      n_checks++; if (out_sign !== C_SIGN_LUI) begin n_fail++; $display("FAIL lui_sign: got %h want %h", out_sign, C_SIGN_LUI); end
`endif
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lui_drained: got %b want 0", out_valid); end
   endtask

   task automatic test_auipc;
      drive_req(2'd1, 5'd3, 32'h00001000);
      n_checks++; if (out_inst !== 32'h00001197) begin n_fail++; $display("FAIL auipc_inst: got %h want 00001197", out_inst); end
      n_checks++; if (out_last !== 1'b1) begin n_fail++; $display("FAIL auipc_last: got %b want 1", out_last); end
`ifdef U_TYPE_ENC_SIGN_EN
      n_checks++; if (out_sign !== C_SIGN_AUIPC) begin n_fail++; $display("FAIL auipc_sign: got %h want %h", out_sign, C_SIGN_AUIPC); end
`endif
      @(posedge clk); #1;
   endtask

   task automatic test_li_two;
      drive_req(2'd2, 5'd10, 32'h12345FFF);
      n_checks++; if (out_inst !== 32'h12346537) begin n_fail++; $display("FAIL li2_lui_inst: got %h want 12346537", out_inst); end
      n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL li2_lui_last: got %b want 0", out_last); end
      n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL li2_ready_low: got %b want 0", req_ready); end
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL li2_addi_valid: got %b want 1", out_valid); end
      n_checks++; if (out_inst !== 32'hFFF50513) begin n_fail++; $display("FAIL li2_addi_inst: got %h want fff50513", out_inst); end
      n_checks++; if (out_last !== 1'b1) begin n_fail++; $display("FAIL li2_addi_last: got %b want 1", out_last); end
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL li2_ready_back: got %b want 1", req_ready); end
`ifdef U_TYPE_ENC_SIGN_EN
      n_checks++; if (out_sign !== C_SIGN_ADDI) begin n_fail++; $display("FAIL li2_addi_sign: got %h want %h", out_sign, C_SIGN_ADDI); end
`endif
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL li2_drained: got %b want 0", out_valid); end
   endtask

   task automatic test_li_boundaries;
      logic [4:0]  rds[3];
      logic [31:0] imms[3];
      logic [31:0] exps[3];
      rds  = '{5'd1, 5'd2, 5'd4};
      imms = '{32'h00000123, 32'hFFFFF800, 32'hABCDE000};
      exps = '{32'h12300093, 32'h80000113, 32'hABCDE237};
      for (int i = 0; i < 3; i++) begin
         drive_req(2'd2, rds[i], imms[i]);
         n_checks++; if (out_inst !== exps[i]) begin n_fail++; $display("FAIL li_bound%0d_inst: got %h want %h", i, out_inst, exps[i]); end
         n_checks++; if (out_last !== 1'b1) begin n_fail++; $display("FAIL li_bound%0d_last: got %b want 1", i, out_last); end
         @(posedge clk); #1;
         n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL li_bound%0d_single: got valid %b want 0", i, out_valid); end
      end
   endtask

   task automatic test_backpressure;
      logic [31:0] lui_w;
      logic [31:0] addi_w;
      lui_w  = m_upper((32'h76543ABC + 32'h800) >> 12, 5'd7, 32'h37);
      addi_w = m_addi(32'hABC, 5'd7, 5'd7);
      out_ready = 1'b0;
      drive_req(2'd2, 5'd7, 32'h76543ABC);
      // Offer another request that must stay unaccepted.
      req_op = 2'd0; req_rd = 5'd8; req_imm = 32'h11111000; req_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         n_checks++; if (out_valid !== 1'b1 || out_inst !== lui_w || out_last !== 1'b0)
            begin n_fail++; $display("FAIL bp_hold%0d: got v=%b %h l=%b want v=1 %h l=0", c, out_valid, out_inst, out_last, lui_w); end
         n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready%0d: got %b want 0", c, req_ready); end
      end
      req_valid = 1'b0;
      out_ready = 1'b1;
      #1;
      n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_release_ready: got %b want 0", req_ready); end
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b1 || out_inst !== addi_w || out_last !== 1'b1)
         begin n_fail++; $display("FAIL bp_second: got v=%b %h l=%b want v=1 %h l=1", out_valid, out_inst, out_last, addi_w); end
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup: got %b want 0", out_valid); end
   endtask

   task automatic test_illegal;
      out_ready = 1'b1;
      drive_req(2'd3, 5'd6, $urandom);
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL ill_err: got %b want 1", err); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ill_valid: got %b want 0", out_valid); end
      @(posedge clk); #1;
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL ill_err_pulse: got %b want 0", err); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ill_valid2: got %b want 0", out_valid); end
   endtask

   task automatic test_random;
      logic [1:0]  op;
      logic [4:0]  rd;
      logic [31:0] imm;
      exp_q.delete(); obs_q.delete(); exp_err = 0; obs_err = 0;
      rand_bp = 1'b1;
      for (int n = 0; n < 200; n++) begin
         op = 2'($urandom_range(0, 3));
         rd = 5'($urandom);
         case ($urandom_range(0, 4))
            0: imm = $urandom & 32'h000007FF;
            1: imm = 32'hFFFFF800 | ($urandom & 32'h000007FF);
            2: imm = $urandom & 32'hFFFFF000;
            default: imm = $urandom;
         endcase
         drive_req(op, rd, imm);
      end
      rand_bp = 1'b0;
      out_ready = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d words want %0d", obs_q.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
         n_checks++; if (obs_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL rand_word%0d: got last=%b %h want last=%b %h", k, obs_q[k][32], obs_q[k][31:0], exp_q[k][32], exp_q[k][31:0]); end
      end
      n_checks++; if (obs_err != exp_err) begin n_fail++; $display("FAIL rand_err_pulses: got %0d want %0d", obs_err, exp_err); end
   endtask

   task automatic test_reset_mid;
      out_ready = 1'b0;
      drive_req(2'd2, 5'd11, 32'h0F0F0F0F);
      #2;
      rstn = 1'b0;
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b want 0", out_valid); end
      n_checks++; if (out_last !== 1'b0 || out_inst !== 32'd0) begin n_fail++; $display("FAIL rmid_clear: got %h l=%b want 0 l=0", out_inst, out_last); end
      @(posedge clk); #1;
      rstn = 1'b1;
      out_ready = 1'b1;
      drive_req(2'd0, 5'd9, 32'hCAFEB000);
      n_checks++; if (out_inst !== 32'hCAFEB4B7 || out_last !== 1'b1) begin n_fail++; $display("FAIL rmid_next: got %h l=%b want cafeb4b7 l=1", out_inst, out_last); end
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_dropped: got %b want 0", out_valid); end
   endtask

   initial begin
      test_reset();
      test_lui();
      test_auipc();
      test_li_two();
      test_li_boundaries();
      test_backpressure();
      test_illegal();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule : tb_u_type_encoder

`default_nettype wire
